// File: rtl/rah_tx_arbiter.sv
// rtl/rah_tx_arbiter.sv - N-channel round-robin merger feeding the single rah_encoder write stream
//
// Purpose:
//   Per-channel elastic FIFOs merged onto one output lane. A registered
//   round-robin arbiter grants one channel at a time and sends up to
//   BURST_MAX words from it before rotating. Every output word carries its
//   source channel tag.
//
// Ports:
//   clk           single clock (tx_pixel_clk domain)
//   rst           synchronous, active-high reset
//   in_valid      per-channel word valid
//   in_data       channel k word at [k*DATA_WIDTH +: DATA_WIDTH]
//   in_ready      per-channel FIFO not full
//   out_valid     output word valid
//   out_data      output word
//   out_ch        source channel of out_data
//   out_ready     encoder can accept
//   grant_active  arbiter is in GRANT
//
// Optional build macro:
//   RAH_ARB_CH0_PRIO_EN  channel 0 wins every IDLE arbitration while it holds
//                        data; its grants leave the round-robin pointer alone.
module rah_tx_arbiter #(
  parameter int NUM_CH     = 4,
  parameter int DATA_WIDTH = 48,
  parameter int FIFO_DEPTH = 4,
  parameter int BURST_MAX  = 16,
  parameter int CH_W       = $clog2(NUM_CH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [NUM_CH-1:0]            in_valid,
  input  logic [NUM_CH*DATA_WIDTH-1:0] in_data,
  output logic [NUM_CH-1:0]            in_ready,
  output logic                         out_valid,
  output logic [DATA_WIDTH-1:0]        out_data,
  output logic [CH_W-1:0]              out_ch,
  input  logic                         out_ready,
  output logic                         grant_active
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int BC_W  = $clog2(BURST_MAX + 1);

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] GRANT = 1'b1;

  logic [DATA_WIDTH-1:0] mem    [NUM_CH][FIFO_DEPTH];
  logic [PTR_W-1:0]      wr_ptr [NUM_CH];
  logic [PTR_W-1:0]      rd_ptr [NUM_CH];
  logic [CNT_W-1:0]      cnt    [NUM_CH];

  logic [0:0]       state;
  logic [CH_W-1:0]  gnt;
  logic [CH_W-1:0]  last_ch;
  logic [BC_W-1:0]  burst_cnt;

  logic [NUM_CH-1:0] push;
  logic [NUM_CH-1:0] pop_vec;
  logic              pop_any;
  logic              sel_found;
  logic              sel_prio;
  logic [CH_W-1:0]   sel_ch;

  // in_ready is gated by rst so nothing is accepted while the FIFOs are being cleared.
  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      in_ready[k] = !rst && (cnt[k] < CNT_W'(FIFO_DEPTH));
    end
  end

  assign push = in_valid & in_ready;

  // Outputs are forced to zero during reset, regardless of the pre-reset state.
  always_comb begin
    grant_active = !rst && (state == GRANT);
    out_valid    = grant_active && (cnt[gnt] != '0);
    out_data     = grant_active ? mem[gnt][rd_ptr[gnt]] : '0;
    out_ch       = grant_active ? gnt : '0;
  end

  assign pop_any = out_valid && out_ready;

  always_comb begin
    for (int k = 0; k < NUM_CH; k++) begin
      pop_vec[k] = pop_any && (gnt == CH_W'(k));
    end
  end

  // Round-robin pick: first non-empty channel starting just after the last grant.
  always_comb begin
    int idx;
    logic [CH_W-1:0] cand;
    sel_found = 1'b0;
    sel_prio  = 1'b0;
    sel_ch    = '0;
    idx       = 0;
    cand      = '0;
    for (int i = 1; i <= NUM_CH; i++) begin
      idx  = (int'(last_ch) + i) % NUM_CH;
      cand = CH_W'(idx);
      if (!sel_found && (cnt[cand] != '0)) begin
        sel_found = 1'b1;
        sel_ch    = cand;
      end
    end
`ifdef RAH_ARB_CH0_PRIO_EN
    if (cnt[0] != '0) begin
      sel_found = 1'b1;
      sel_prio  = 1'b1;
      sel_ch    = '0;
    end
`endif
  end

  // FIFO storage carries no reset; validity is tracked entirely by cnt.
  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (push[k]) mem[k][wr_ptr[k]] <= in_data[k*DATA_WIDTH +: DATA_WIDTH];
    end
  end

  always_ff @(posedge clk) begin
    for (int k = 0; k < NUM_CH; k++) begin
      if (rst) begin
        wr_ptr[k] <= '0;
        rd_ptr[k] <= '0;
        cnt[k]    <= '0;
      end else begin
        if (push[k])    wr_ptr[k] <= wr_ptr[k] + 1'b1;
        if (pop_vec[k]) rd_ptr[k] <= rd_ptr[k] + 1'b1;
        case ({push[k], pop_vec[k]})
          2'b10:   cnt[k] <= cnt[k] + 1'b1;
          2'b01:   cnt[k] <= cnt[k] - 1'b1;
          default: cnt[k] <= cnt[k];
        endcase
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      gnt       <= '0;
      last_ch   <= CH_W'(NUM_CH - 1);
      burst_cnt <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (sel_found) begin
            state     <= GRANT;
            gnt       <= sel_ch;
            burst_cnt <= '0;
            if (!sel_prio) last_ch <= sel_ch;
          end
        end
        GRANT: begin
          if (pop_any) begin
            burst_cnt <= burst_cnt + 1'b1;
            // A same-cycle push to the granted channel keeps the burst alive.
            if (((cnt[gnt] == CNT_W'(1)) && !push[gnt]) ||
                (burst_cnt + 1'b1 == BC_W'(BURST_MAX))) begin
              state <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/rah_tx_arbiter.md
Name: rah_tx_arbiter

Overview:
- Parametrised N-channel merger between app write ports and the single rah_encoder write stream.
- Per-channel elastic FIFO, round-robin grant with a bounded burst length, and a channel tag on every output word.
- Replaces hard-wired per-app wr_data/send_data fan-in, so apps can share one encoder lane with fair bandwidth.

Parameters:
- NUM_CH, 4, number of app channels (>=2).
- DATA_WIDTH, 48, RAH packet word width.
- FIFO_DEPTH, 4, words per channel FIFO; power of 2, >=2.
- BURST_MAX, 16, max words sent per grant before rotating (>=1).
- CH_W, $clog2(NUM_CH), width of the channel tag (derived, not overridden).

Ports:
- clk  in  1  single clock (tx_pixel_clk domain).
- rst  in  1  synchronous, active-high reset.
- in_valid  in  NUM_CH  per-channel word valid.
- in_data  in  NUM_CH*DATA_WIDTH  channel k at bits [k*DATA_WIDTH +: DATA_WIDTH].
- in_ready  out  NUM_CH  per-channel FIFO not full.
- out_valid  out  1  output word valid.
- out_data  out  DATA_WIDTH  output word.
- out_ch  out  CH_W  source channel of out_data.
- out_ready  in  1  encoder can accept (driven from ~wr_prog_fifo_full).
- grant_active  out  1  arbiter in GRANT state.

Behaviour:
- Reset (rst=1 at a clk edge): all FIFOs are emptied.
  - State = IDLE; last-grant pointer = NUM_CH-1, so channel 0 wins first.
  - burst_cnt = 0.
  - Outputs while rst is high: out_valid=0, out_data=0, out_ch=0, grant_active=0, in_ready=0.
  - in_ready goes to 1 in the first cycle after rst deasserts.
  - Reset mid-burst discards all queued words; no partial word is emitted.
- Push:
  - in_ready[k] = (count[k] < FIFO_DEPTH). It does not depend on a same-cycle pop.
  - A word is written on in_valid[k] & in_ready[k], and is visible in the FIFO the next cycle.
  - in_valid with in_ready=0 is ignored: no write, no error.
  - Simultaneous push and pop on one FIFO is allowed; the count is unchanged.
- Arbiter FSM (registered):
  - IDLE:
    - Scan channels round-robin starting at last+1 (mod NUM_CH) and select the first with count>0.
    - Next cycle: state=GRANT, gnt=selected, last=selected, burst_cnt=0.
    - If none is non-empty, stay IDLE.
  - GRANT:
    - out_valid = (count[gnt]>0); out_data = head of FIFO gnt (combinational mux of registered storage); out_ch = gnt.
    - Pop on out_valid & out_ready; then burst_cnt+1.
    - Go to IDLE after a pop when either:
      - the FIFO becomes empty (count was 1, with no same-cycle push to that channel), or
      - burst_cnt+1 == BURST_MAX.
    - Otherwise stay in GRANT.
    - out_ready=0 holds state; out_valid/out_data/out_ch stay stable until accepted.
  - Every GRANT->IDLE transition costs one idle output cycle.
- Latency: with IDLE and an empty arbiter, a word pushed at edge t is presented at t+2 (out_valid high in the cycle after t+1).
- A word pushed to the granted FIFO during GRANT extends the burst (subject to BURST_MAX).
- Ordering: words within a channel are strictly FIFO order. Interleaving across channels occurs only at grant boundaries.
- No arithmetic overflow:
  - count is $clog2(FIFO_DEPTH)+1 bits.
  - burst_cnt is $clog2(BURST_MAX+1) bits.
  - Pointers wrap modulo FIFO_DEPTH.

Optional Feature:
- Macro: RAH_ARB_CH0_PRIO_EN.
- Defined:
  - Channel 0 (control/version app) has strict priority in IDLE: if count[0]>0, channel 0 is granted regardless of the last pointer.
  - A channel-0 grant does not update the last pointer, so the round-robin fairness among channels 1..NUM_CH-1 is unaffected.
  - A running burst is never pre-empted.
- Undefined: channel 0 is an ordinary round-robin participant.

Test Plan:
- Reset and single word: rst 2 cycles, then push 0x0000_1234_5678 on ch2 at edge t, out_ready=1 -> out_valid at t+2 with out_data=0x000012345678, out_ch=2; in_ready all 1 after reset.
- Fairness: ch0..ch3 each preload 3 words, BURST_MAX=16 -> output order ch0 x3, ch1 x3, ch2 x3, ch3 x3, with one idle cycle between bursts.
- Burst cap: BURST_MAX=2, ch1 holds 4 words, ch3 holds 1 -> ch1 w0,w1, then ch3 w0, then ch1 w2,w3.
- Backpressure/full: out_ready=0, push 5 words on ch0 with FIFO_DEPTH=4 -> in_ready[0]=0 after the 4th; 5th dropped; out_data held stable; release -> exactly 4 words out in order.
- Reset mid-burst: ch1 streaming 3 of 6 words, assert rst 1 cycle -> out_valid=0 during reset, nothing emitted afterwards, FIFOs empty, next grant starts from ch0.
- RAH_ARB_CH0_PRIO_EN defined: ch1 and ch2 busy, push to ch0 during ch1 burst -> ch1 burst completes, ch0 granted next, then ch2 (not ch1); undefined -> ch2 before ch0.
